// File: rtl/sn_pkg.sv
// -----------------------------------------------------------------------------
// sn_pkg
// Shared definitions for the SN76489-compatible CPU write decoder:
//   - register index constants as seen by the tone/attenuation register bank
//   - bit positions inside a CPU write byte (latch flag, index field)
//   - decoder FSM state encoding
//   - default busy length of the READY handshake
// -----------------------------------------------------------------------------
package sn_pkg;

  // Register index = {channel[1:0], type}; type 0 = tone/noise, 1 = attenuation
  localparam logic [2:0] TONE1 = 3'd0;
  localparam logic [2:0] ATT1  = 3'd1;
  localparam logic [2:0] TONE2 = 3'd2;
  localparam logic [2:0] ATT2  = 3'd3;
  localparam logic [2:0] TONE3 = 3'd4;
  localparam logic [2:0] ATT3  = 3'd5;
  localparam logic [2:0] NOISE = 3'd6;
  localparam logic [2:0] ATTN  = 3'd7;

  // Field positions inside a written byte
  localparam int LATCH_BIT = 7;
  localparam int IDX_MSB   = 6;
  localparam int IDX_LSB   = 4;

  localparam int BUSY_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_BUSY   = 2'd2
  } sn_state_t;

  // Only the three tone registers carry a 10-bit value split over two writes.
  function automatic logic is_tone(input logic [2:0] idx);
    return (idx == TONE1) || (idx == TONE2) || (idx == TONE3);
  endfunction

endpackage

// File: rtl/sn_strobe_sync.sv
// -----------------------------------------------------------------------------
// sn_strobe_sync
// Brings the asynchronous active-low CPU write strobe into the clk domain with
// a 2-flop synchronizer and produces a one-cycle pulse on its falling edge.
// All flops reset to 1 (strobe idle) so releasing reset never fakes an edge.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   i_we_n  raw CPU write strobe, active low
//   o_fall  one-cycle pulse: synchronized strobe went 1 -> 0
// -----------------------------------------------------------------------------
module sn_strobe_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_we_n,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_we_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/sn_write_decoder.sv
// -----------------------------------------------------------------------------
// sn_write_decoder
// Byte-wide CPU write port of the SN76489-compatible sound core. Decodes the
// latch/data byte protocol and issues single-cycle loads to the register bank,
// holding READY low while a write is in flight.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   data_in  CPU write data, stable while we_n is low
//   we_n     CPU write strobe, active low, asynchronous to clk
//   ready    1 = idle and accepting writes, 0 = busy
//   adress   register index {channel[1:0], type}
//   value    register value, zero-extended to 10 bits
//   load     one-cycle write strobe to the register bank
// -----------------------------------------------------------------------------
module sn_write_decoder
  import sn_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       we_n,
  output logic       ready,
  output logic [2:0] adress,
  output logic [9:0] value,
  output logic       load
);

  localparam logic [7:0] CNT_INIT = 8'(BUSY_CYCLES - 1);

  logic       w_fall;
  sn_state_t  r_state;
  sn_state_t  w_next;

  logic [7:0] r_byte;
  logic [7:0] r_cnt;
  logic [2:0] r_idx;
  logic [3:0] r_lo [3];
  logic [5:0] r_hi [3];

  logic       r_ready;
  logic       r_load;
  logic [2:0] r_adress;
  logic [9:0] r_value;

  logic       w_is_latch;
  logic [2:0] w_idx;
  logic       w_tone;
  logic [1:0] w_ch;
  logic [3:0] w_lo_sel;
  logic [5:0] w_hi_sel;
  logic [9:0] w_value;

  sn_strobe_sync u_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we_n (we_n),
    .o_fall (w_fall)
  );

  // ---- decode of the captured byte ----
  always_comb begin
    w_is_latch = r_byte[LATCH_BIT];
    // Data bytes reuse the index from the most recent latch byte.
    w_idx      = w_is_latch ? r_byte[IDX_MSB:IDX_LSB] : r_idx;
    w_tone     = is_tone(w_idx);
    w_ch       = w_idx[2:1];

    w_lo_sel = r_lo[0];
    w_hi_sel = r_hi[0];
    case (w_ch)
      2'd1:    begin w_lo_sel = r_lo[1]; w_hi_sel = r_hi[1]; end
      2'd2:    begin w_lo_sel = r_lo[2]; w_hi_sel = r_hi[2]; end
      default: begin w_lo_sel = r_lo[0]; w_hi_sel = r_hi[0]; end
    endcase

    // Tone values merge the freshly written field with the other half's shadow.
    if (!w_tone)
      w_value = {6'b0, r_byte[3:0]};
    else if (w_is_latch)
      w_value = {w_hi_sel, r_byte[3:0]};
    else
      w_value = {r_byte[5:0], w_lo_sel};
  end

  // ---- FSM next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_fall) w_next = ST_DECODE;
      ST_DECODE: w_next = ST_BUSY;
      ST_BUSY:   if (r_cnt == 8'd0) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // ---- capture / load / busy countdown ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte   <= 8'd0;
      r_cnt    <= 8'd0;
      r_idx    <= TONE1;
      r_ready  <= 1'b1;
      r_load   <= 1'b0;
      r_adress <= 3'd0;
      r_value  <= 10'd0;
      for (int i = 0; i < 3; i++) begin
        r_lo[i] <= 4'd0;
        r_hi[i] <= 6'd0;
      end
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_byte  <= data_in;
            r_ready <= 1'b0;
          end
        end
        ST_DECODE: begin
          r_adress <= w_idx;
          r_value  <= w_value;
          r_load   <= 1'b1;
          r_cnt    <= CNT_INIT;
          if (w_is_latch) r_idx <= w_idx;
          if (w_tone) begin
            for (int i = 0; i < 3; i++) begin
              if (w_ch == 2'(i)) begin
                if (w_is_latch) r_lo[i] <= r_byte[3:0];
                else            r_hi[i] <= r_byte[5:0];
              end
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == 8'd0) r_ready <= 1'b1;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign ready  = r_ready;
  assign load   = r_load;
  assign adress = r_adress;
  assign value  = r_value;

endmodule

// File: doc/sn_write_decoder.md
Name: sn_write_decoder

Overview:
Byte-wide CPU write interface for the SN76489-compatible sound core. Sits directly upstream of the tone/attenuation control register bank. It accepts 8-bit writes on an asynchronous active-low write strobe and decodes the chip's latch/data byte protocol. It emits one-cycle register-load pulses (adress/value/load) for the register bank, and drives a READY handshake that is held low while a write is being processed.

Parameters:
BUSY_CYCLES, 32, number of BUSY-state cycles READY stays low after DECODE; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
data_in  input  8  CPU write data; must be stable while we_n is low
we_n  input  1  CPU write strobe, active low, asynchronous to clk
ready  output  1  1 = idle and accepting writes; 0 = busy
adress  output  3  register index {channel[1:0], type}; 0/2/4 tone, 1/3/5 attenuation, 6 noise, 7 noise attenuation
value  output  10  register value, zero-extended
load  output  1  single-cycle write strobe to the register bank

Behaviour:
- Reset is asynchronous and active-high, and can occur at any time. Reset values:
  - ready=1, load=0, adress=0, value=0.
  - latched index=0; tone low-nibble shadows (3x4) and high-field shadows (3x6) all 0.
  - Synchronizer flops=1, so no spurious edge is seen at release.
  - FSM returns to IDLE.
- we_n path: 2-flop synchronizer, then falling-edge detect (previous sync=1, current sync=0). Call the detect cycle E.
- FSM states: IDLE, DECODE, BUSY.
  - IDLE: on edge at E, capture byte_r<=data_in, set ready<=0, go to DECODE.
  - DECODE (cycle E+1): register adress, value and load=1; go to BUSY; cnt<=BUSY_CYCLES-1.
  - BUSY: load=0. Decrement cnt each cycle. When cnt==0, go to IDLE and set ready<=1.
- Timing:
  - load is high for exactly one cycle, cycle E+2.
  - ready is low for exactly BUSY_CYCLES+1 cycles, cycles E+1 through E+BUSY_CYCLES+1.
- Latch byte (byte_r[7]=1):
  - idx = byte_r[6:4]; latched index <= idx; nibble n = byte_r[3:0]; adress = idx.
  - idx in {0,2,4}: tone low-nibble shadow[idx/2] <= n; value = {hi_shadow[idx/2], n}.
  - Any other idx: value = {6'b0, n}. Noise (6) uses value[2:0] downstream; the full nibble is still driven.
- Data byte (byte_r[7]=0): adress = latched index.
  - Latched index is tone: hi_shadow <= byte_r[5:0]; value = {byte_r[5:0], lo_shadow}. byte_r[6] is ignored.
  - Latched index is not tone: value = {6'b0, byte_r[3:0]}.
  - A data byte after reset with no prior latch byte writes index 0.
- Falling edges detected in DECODE or BUSY are dropped: no capture, no load, no state change. A strobe still low when IDLE is re-entered is not re-detected; a new falling edge is required.
- adress and value hold their last values between loads.
- Reset mid-BUSY: ready=1 immediately (asynchronous), no pending load is issued, all shadows clear.
- Width rule: all values are zero-extended to 10 bits. No truncation is needed.

Decomposition:
- Package sn_pkg:
  - register index constants: TONE1=0, ATT1=1, TONE2=2, ATT2=3, TONE3=4, ATT3=5, NOISE=6, ATTN=7
  - byte field positions: LATCH_BIT=7, IDX_MSB=6, IDX_LSB=4
  - FSM state enum
  - default BUSY_CYCLES
- Sub-module sn_strobe_sync: 2-flop synchronizer plus falling-edge pulse, reset to idle-high.

Test Plan:
- Write 0x8E then 0x0F, waiting for ready between writes -> load #1: adress=0, value=0x00E. Load #2: adress=0, value=0x0FE.
- Write 0xA3 then 0x3F -> adress=2, value=0x003, then adress=2, value=0x3F3. Channel 1 shadows are unchanged.
- Write 0x9A -> exactly one load, adress=1, value=0x00A. ready low for 33 cycles (BUSY_CYCLES=32).
- Write 0xB0 then data byte 0x07 -> adress=3, value=0x000, then adress=3, value=0x007. Write 0xE5 -> adress=6, value=0x005.
- Issue a second we_n pulse (0x81) 5 cycles after the first (0x9F) -> only one load (adress=1, value=0x00F). The 0x81 byte is dropped.
- Assert rst 10 cycles into BUSY -> ready=1 asynchronously, no load. A following data byte 0x12 -> adress=0, value=0x120.
